// File: rtl/id_operand_fetch.sv
// rtl/id_operand_fetch.sv - decode-side operand fetch, forwarding and ID/EX register
//
// Drives both register-file read ports, resolves each source operand from the
// EX/MEM forwarding paths or the register file, detects load-use hazards and
// captures the resolved instruction in the ID/EX pipeline register.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   flush                     drop the in-flight instruction, accept nothing
//   in_valid / in_ready       decoded-instruction handshake
//   in_pc, in_aluop           PC and opcode, passed through
//   in_rs/in_rt, *_en         source registers and whether each is used
//   in_use_imm, in_imm        operand 2 comes from the extended immediate
//   in_wd, in_wreg            destination register and write enable
//   in_is_load                instruction is a load
//   re1/re2, raddr1/raddr2    register-file read ports
//   rdata1/rdata2             register-file read data (WB bypass already applied)
//   ex_wreg/ex_is_load/ex_wd/ex_wdata   EX-stage forwarding source
//   mem_wreg/mem_wd/mem_wdata           MEM-stage forwarding source
//   out_valid / out_ready     ID/EX handshake
//   out_pc, out_reg1, out_reg2, out_aluop, out_wd, out_wreg, out_is_load
//                             registered instruction and operands
//   stall_cnt                 load-use stall cycles since reset (wraps)

`timescale 1ns/1ps

module id_operand_fetch #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int OP_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [OP_W-1:0]   in_aluop,
   input  logic [ADDR_W-1:0] in_rs,
   input  logic [ADDR_W-1:0] in_rt,
   input  logic              in_rs_en,
   input  logic              in_rt_en,
   input  logic              in_use_imm,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [ADDR_W-1:0] in_wd,
   input  logic              in_wreg,
   input  logic              in_is_load,
   output logic              re1,
   output logic              re2,
   output logic [ADDR_W-1:0] raddr1,
   output logic [ADDR_W-1:0] raddr2,
   input  logic [DATA_W-1:0] rdata1,
   input  logic [DATA_W-1:0] rdata2,
   input  logic              ex_wreg,
   input  logic              ex_is_load,
   input  logic [ADDR_W-1:0] ex_wd,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic              mem_wreg,
   input  logic [ADDR_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_reg1,
   output logic [DATA_W-1:0] out_reg2,
   output logic [OP_W-1:0]   out_aluop,
   output logic [ADDR_W-1:0] out_wd,
   output logic              out_wreg,
   output logic              out_is_load,
   output logic [31:0]       stall_cnt
);

   logic [DATA_W-1:0] op1_val;
   logic [DATA_W-1:0] op2_val;
   logic              op1_haz;
   logic              op2_haz;
   logic              hazard;
   logic              advance;

   // Read ports: operand 2 is not read when the immediate replaces rt.
   assign re1    = in_valid & in_rs_en;
   assign raddr1 = in_rs;
   assign re2    = in_valid & in_rt_en & ~in_use_imm;
   assign raddr2 = in_rt;

   // Operand 1. EX is younger than MEM, so it wins when both target the
   // same register. A load in EX has no data yet: that is the hazard case.
   always_comb begin
      op1_val = '0;
      op1_haz = 1'b0;
      if (in_rs_en && in_rs != '0) begin
         if (ex_wreg && ex_wd == in_rs) begin
            if (ex_is_load)
               op1_haz = 1'b1;
            else
               op1_val = ex_wdata;
         end else if (mem_wreg && mem_wd == in_rs) begin
            op1_val = mem_wdata;
         end else begin
            op1_val = rdata1;
         end
      end
   end

   // Operand 2. The immediate bypasses rt entirely, so an EX load to rt
   // cannot stall an immediate-form instruction.
   always_comb begin
      op2_val = '0;
      op2_haz = 1'b0;
      if (in_use_imm) begin
         op2_val = in_imm;
      end else if (in_rt_en && in_rt != '0) begin
         if (ex_wreg && ex_wd == in_rt) begin
            if (ex_is_load)
               op2_haz = 1'b1;
            else
               op2_val = ex_wdata;
         end else if (mem_wreg && mem_wd == in_rt) begin
            op2_val = mem_wdata;
         end else begin
            op2_val = rdata2;
         end
      end
   end

   // Both operands hazarded still collapse into a single stall.
   assign hazard   = in_valid & (op1_haz | op2_haz);
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance & ~hazard & ~flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_pc      <= '0;
         out_reg1    <= '0;
         out_reg2    <= '0;
         out_aluop   <= '0;
         out_wd      <= '0;
         out_wreg    <= 1'b0;
         out_is_load <= 1'b0;
         stall_cnt   <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (advance) begin
         if (hazard) begin
            // Bubble: the load moves on to MEM, where it can be forwarded.
            out_valid <= 1'b0;
            stall_cnt <= stall_cnt + 32'd1;
         end else if (in_valid) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_reg1    <= op1_val;
            out_reg2    <= op2_val;
            out_aluop   <= in_aluop;
            out_wd      <= in_wd;
            out_wreg    <= in_wreg;
            out_is_load <= in_is_load;
         end else begin
            out_valid <= 1'b0;
         end
      end
      // !advance: downstream backpressure, everything holds.
   end

endmodule

// File: tb/tb_id_operand_fetch.sv
// tb/tb_id_operand_fetch.sv - directed scoreboard bench for id_operand_fetch

`timescale 1ns/1ps

module tb_id_operand_fetch;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic        in_valid, in_ready;
   logic [31:0] in_pc, in_imm;
   logic [7:0]  in_aluop;
   logic [4:0]  in_rs, in_rt, in_wd;
   logic        in_rs_en, in_rt_en, in_use_imm, in_wreg, in_is_load;
   logic        re1, re2;
   logic [4:0]  raddr1, raddr2;
   logic [31:0] rdata1, rdata2;
   logic        ex_wreg, ex_is_load;
   logic [4:0]  ex_wd;
   logic [31:0] ex_wdata;
   logic        mem_wreg;
   logic [4:0]  mem_wd;
   logic [31:0] mem_wdata;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_reg1, out_reg2;
   logic [7:0]  out_aluop;
   logic [4:0]  out_wd;
   logic        out_wreg, out_is_load;
   logic [31:0] stall_cnt;

   always #5 clk = ~clk;

   id_operand_fetch dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_aluop(in_aluop),
      .in_rs(in_rs), .in_rt(in_rt), .in_rs_en(in_rs_en), .in_rt_en(in_rt_en),
      .in_use_imm(in_use_imm), .in_imm(in_imm),
      .in_wd(in_wd), .in_wreg(in_wreg), .in_is_load(in_is_load),
      .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1), .rdata2(rdata2),
      .ex_wreg(ex_wreg), .ex_is_load(ex_is_load), .ex_wd(ex_wd), .ex_wdata(ex_wdata),
      .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_reg1(out_reg1), .out_reg2(out_reg2),
      .out_aluop(out_aluop), .out_wd(out_wd), .out_wreg(out_wreg),
      .out_is_load(out_is_load), .stall_cnt(stall_cnt)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [7:0]  op;
      logic [4:0]  wd;
      logic        wreg;
      logic        ld;
   } ent_t;

   ent_t sb[$];
   ent_t none = '0;
   int   vectors = 0;
   int   errors  = 0;

   function automatic ent_t mk(input logic [31:0] pc, r1, r2, input logic [7:0] op,
                               input logic [4:0] wd, input logic wreg, ld);
      ent_t e;
      e.pc = pc; e.r1 = r1; e.r2 = r2; e.op = op; e.wd = wd; e.wreg = wreg; e.ld = ld;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic [31:0] pc, input logic [7:0] op,
                      input logic [4:0] rs, rt, input logic rs_en, rt_en, use_imm,
                      input logic [31:0] imm, input logic [4:0] wd, input logic wreg, ld);
      in_valid = 1'b1; in_pc = pc; in_aluop = op; in_rs = rs; in_rt = rt;
      in_rs_en = rs_en; in_rt_en = rt_en; in_use_imm = use_imm; in_imm = imm;
      in_wd = wd; in_wreg = wreg; in_is_load = ld;
   endtask

   task automatic set_ex(input logic wreg, ld, input logic [4:0] wd, input logic [31:0] wdata);
      ex_wreg = wreg; ex_is_load = ld; ex_wd = wd; ex_wdata = wdata;
   endtask

   task automatic set_mem(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata);
      mem_wreg = wreg; mem_wd = wd; mem_wdata = wdata;
   endtask

   // One cycle: check acceptance, retire any output EX takes, queue what
   // should be accepted, then advance to the next falling edge.
   task automatic tick(input logic exp_rdy, input ent_t e);
      ent_t got;
      #1;
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      if (out_valid && out_ready) begin
         chk("sb_has_entry", {31'b0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            got = sb.pop_front();
            chk("out_pc",      out_pc,      got.pc);
            chk("out_reg1",    out_reg1,    got.r1);
            chk("out_reg2",    out_reg2,    got.r2);
            chk("out_aluop",   {24'b0, out_aluop}, {24'b0, got.op});
            chk("out_wd",      {27'b0, out_wd},    {27'b0, got.wd});
            chk("out_wreg",    {31'b0, out_wreg},    {31'b0, got.wreg});
            chk("out_is_load", {31'b0, out_is_load}, {31'b0, got.ld});
         end
      end
      if (in_valid && exp_rdy) sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; in_pc = '0; in_aluop = '0; in_rs = '0; in_rt = '0;
      in_rs_en = 1'b0; in_rt_en = 1'b0; in_use_imm = 1'b0; in_imm = '0;
      in_wd = '0; in_wreg = 1'b0; in_is_load = 1'b0;
      rdata1 = '0; rdata2 = '0;
      set_ex(0, 0, 0, 0);
      set_mem(0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_reg1", out_reg1, 32'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);

      // Plain register-file operands
      drv(32'h100, 8'h11, 5'd3, 5'd4, 1, 1, 0, 32'h0, 5'd6, 1, 0);
      rdata1 = 32'h11; rdata2 = 32'h22;
      #1;
      chk("re1", {31'b0, re1}, 32'd1);
      chk("re2", {31'b0, re2}, 32'd1);
      chk("raddr1", {27'b0, raddr1}, 32'd3);
      chk("raddr2", {27'b0, raddr2}, 32'd4);
      tick(1, mk(32'h100, 32'h11, 32'h22, 8'h11, 5'd6, 1, 0));
      chk("t1_out_valid", {31'b0, out_valid}, 32'd1);

      // EX beats MEM; rt disabled gives zero
      drv(32'h200, 8'h22, 5'd5, 5'd0, 1, 0, 0, 32'h0, 5'd8, 1, 0);
      set_ex(1, 0, 5'd5, 32'hAAAA);
      set_mem(1, 5'd5, 32'hBBBB);
      rdata1 = 32'h5555;
      #1;
      chk("re2_off", {31'b0, re2}, 32'd0);
      tick(1, mk(32'h200, 32'hAAAA, 32'h0, 8'h22, 5'd8, 1, 0));

      // MEM forwarding with EX idle
      drv(32'h300, 8'h23, 5'd5, 5'd0, 1, 0, 0, 32'h0, 5'd8, 1, 0);
      set_ex(0, 0, 5'd0, 32'h0);
      tick(1, mk(32'h300, 32'hBBBB, 32'h0, 8'h23, 5'd8, 1, 0));

      // Load-use on rt: one bubble, then MEM forwards the load data
      drv(32'h400, 8'h33, 5'd0, 5'd7, 0, 1, 0, 32'h0, 5'd9, 1, 0);
      set_ex(1, 1, 5'd7, 32'hDEAD);
      set_mem(0, 5'd0, 32'h0);
      rdata2 = 32'h7777;
      tick(0, none);
      chk("lu_bubble", {31'b0, out_valid}, 32'd0);
      chk("lu_stall_cnt", stall_cnt, 32'd1);
      set_ex(0, 0, 5'd0, 32'h0);
      set_mem(1, 5'd7, 32'h1234);
      tick(1, mk(32'h400, 32'h0, 32'h1234, 8'h33, 5'd9, 1, 0));

      // rs = r0 ignores an EX write to r0
      drv(32'h500, 8'h44, 5'd0, 5'd0, 1, 0, 0, 32'h0, 5'd10, 1, 0);
      set_ex(1, 0, 5'd0, 32'hFFFF);
      set_mem(0, 5'd0, 32'h0);
      rdata1 = 32'h9999;
      tick(1, mk(32'h500, 32'h0, 32'h0, 8'h44, 5'd10, 1, 0));

      // Immediate replaces rt: EX load to rt must not stall
      drv(32'h600, 8'h55, 5'd0, 5'd9, 0, 1, 1, 32'hFFFF8000, 5'd11, 1, 1);
      set_ex(1, 1, 5'd9, 32'h0);
      #1;
      chk("re2_imm", {31'b0, re2}, 32'd0);
      tick(1, mk(32'h600, 32'h0, 32'hFFFF8000, 8'h55, 5'd11, 1, 1));
      chk("imm_stall_cnt", stall_cnt, 32'd1);

      // Backpressure for three cycles: everything holds
      out_ready = 1'b0;
      drv(32'h700, 8'h66, 5'd1, 5'd2, 1, 1, 0, 32'h0, 5'd12, 0, 0);
      set_ex(0, 0, 5'd0, 32'h0);
      rdata1 = 32'hA1; rdata2 = 32'hA2;
      for (int i = 0; i < 3; i++) begin
         chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
         chk("bp_out_pc", out_pc, 32'h600);
         chk("bp_out_reg2", out_reg2, 32'hFFFF8000);
         chk("bp_out_wd", {27'b0, out_wd}, 32'd11);
         chk("bp_stall_cnt", stall_cnt, 32'd1);
         tick(0, none);
      end
      out_ready = 1'b1;
      tick(1, mk(32'h700, 32'hA1, 32'hA2, 8'h66, 5'd12, 0, 0));

      // Both operands hit the same EX load: counted once
      drv(32'h800, 8'h77, 5'd7, 5'd7, 1, 1, 0, 32'h0, 5'd13, 1, 0);
      set_ex(1, 1, 5'd7, 32'h0);
      tick(0, none);
      chk("dbl_bubble", {31'b0, out_valid}, 32'd0);
      chk("dbl_stall_cnt", stall_cnt, 32'd2);

      // Flush during the stall: nothing accepted, no extra stall count
      flush = 1'b1;
      tick(0, none);
      chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_stall_cnt", stall_cnt, 32'd2);
      flush = 1'b0;

      // Reset mid-stream while a hazard is pending
      drv(32'h900, 8'h88, 5'd1, 5'd0, 1, 0, 0, 32'h0, 5'd14, 1, 0);
      set_ex(0, 0, 5'd0, 32'h0);
      rdata1 = 32'hC1;
      tick(1, mk(32'h900, 32'hC1, 32'h0, 8'h88, 5'd14, 1, 0));
      rst = 1'b1;
      drv(32'hA00, 8'h99, 5'd7, 5'd0, 1, 0, 0, 32'h0, 5'd15, 1, 0);
      set_ex(1, 1, 5'd7, 32'h0);
      tick(0, none);
      rst = 1'b0;
      chk("mr_out_valid", {31'b0, out_valid}, 32'd0);
      chk("mr_out_pc", out_pc, 32'h0);
      chk("mr_out_reg1", out_reg1, 32'h0);
      chk("mr_out_reg2", out_reg2, 32'h0);
      chk("mr_out_aluop", {24'b0, out_aluop}, 32'h0);
      chk("mr_out_wd", {27'b0, out_wd}, 32'h0);
      chk("mr_out_wreg", {31'b0, out_wreg}, 32'h0);
      chk("mr_out_is_load", {31'b0, out_is_load}, 32'h0);
      chk("mr_stall_cnt", stall_cnt, 32'h0);
      #1;
      chk("mr_in_ready_haz", {31'b0, in_ready}, 32'd0);
      set_ex(0, 0, 5'd0, 32'h0);
      rdata1 = 32'hD1;
      #1;
      chk("mr_in_ready_clr", {31'b0, in_ready}, 32'd1);
      tick(1, mk(32'hA00, 32'hD1, 32'h0, 8'h99, 5'd15, 1, 0));

      in_valid = 1'b0;
      tick(1, none);
      chk("sb_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/id_operand_fetch.md
Name: id_operand_fetch

Overview:
- Decode-side operand stage that sits directly upstream of the register file: it drives both regfile read ports and consumes rdata1/rdata2.
- Resolves EX/MEM forwarding and load-use hazards, and selects the immediate where required.
- Registers the resolved operands into the ID/EX pipeline register, with a valid/ready handshake on both sides, flush support and a stall counter.

Parameters:
DATA_W, 32, operand/data width
ADDR_W, 5, register address width (register 0 hard-wired zero)
OP_W, 8, ALU opcode width, passed through unchanged

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  discard in-flight instruction (branch/exception)
in_valid  in  1  decoded instruction present
in_ready  out  1  instruction accepted this cycle
in_pc  in  DATA_W  instruction PC
in_aluop  in  OP_W  ALU opcode
in_rs, in_rt  in  ADDR_W  source register numbers
in_rs_en, in_rt_en  in  1  source actually used
in_use_imm  in  1  operand 2 = in_imm instead of rt
in_imm  in  DATA_W  already-extended immediate
in_wd  in  ADDR_W  destination register
in_wreg  in  1  instruction writes in_wd
in_is_load  in  1  instruction is a load
re1, re2  out  1  regfile read enables
raddr1, raddr2  out  ADDR_W  regfile read addresses
rdata1, rdata2  in  DATA_W  regfile read data (already WB-bypassed)
ex_wreg, ex_is_load  in  1  instruction currently in EX writes / is a load
ex_wd  in  ADDR_W  EX destination
ex_wdata  in  DATA_W  EX result
mem_wreg  in  1  MEM-stage write enable
mem_wd  in  ADDR_W  MEM destination
mem_wdata  in  DATA_W  MEM result
out_valid  out  1  ID/EX register holds an instruction
out_ready  in  1  EX accepts
out_pc, out_reg1, out_reg2  out  DATA_W  registered PC/operands
out_aluop  out  OP_W  registered opcode
out_wd  out  ADDR_W  registered destination
out_wreg, out_is_load  out  1  registered control
stall_cnt  out  32  load-use stall cycles since reset

Behaviour:
- Read ports (combinational): re1=in_valid&in_rs_en, raddr1=in_rs; re2=in_valid&in_rt_en&!in_use_imm, raddr2=in_rt.
- Operand n source selection, first matching rule wins (src = rs for operand 1, rt for operand 2):
  - port disabled: 0
  - src==0: 0
  - ex_wreg & ex_wd==src & !ex_is_load: ex_wdata
  - ex_wreg & ex_wd==src & ex_is_load: hazard
  - mem_wreg & mem_wd==src: mem_wdata
  - otherwise: rdata
- Operand 2 with in_use_imm=1 is in_imm; it never triggers a hazard on rt.
- hazard = in_valid & (either operand flagged hazard).
- advance = !out_valid | out_ready.
- in_ready = advance & !hazard & !flush.
- Register update on each clk edge; priority order:
  1. rst: all out_* registers 0, stall_cnt 0.
  2. flush: out_valid<=0; the input is not accepted.
  3. advance & hazard: bubble inserted (out_valid<=0, other out_* hold); stall_cnt+=1.
  4. advance & in_valid & !hazard: load all out_* from inputs and resolved operands; out_valid<=1.
  5. advance & !in_valid: out_valid<=0.
  6. !advance: hold all out_*; stall_cnt unchanged (backpressure is not a load-use stall).
- Latency: 1 cycle input-to-out_valid when no hazard; load-use adds exactly 1 bubble, after which the load sits in MEM and forwarding via mem_wdata resolves the operand.
- stall_cnt wraps from 0xFFFFFFFF to 0.
- Both operands hazarded in the same cycle: a single stall cycle, counted once.
- Reset mid-stall: stall abandoned, outputs zero on the next cycle, in_ready recomputed combinationally.
- Regfile write-to-read bypass is owned by the regfile; this block adds no WB path.

Test Plan:
- Reset, then in_valid with rs=3/rt=4, rdata1=0x11, rdata2=0x22 -> next cycle out_valid=1, out_reg1=0x11, out_reg2=0x22; re1=re2=1, raddr1=3, raddr2=4.
- EX writes r5=0xAAAA (non-load) and MEM writes r5=0xBBBB, input rs=5 -> out_reg1=0xAAAA (EX priority); with EX idle -> out_reg1=0xBBBB.
- EX is a load to r7, input rt=7 -> in_ready=0 for 1 cycle, bubble (out_valid=0), stall_cnt=1; next cycle load in MEM, mem_wdata=0x1234 -> out_reg2=0x1234, in_ready=1.
- rs=0 with EX writing r0=0xFFFF -> out_reg1=0; in_use_imm=1, in_imm=0xFFFF8000, rt matches an EX load -> no stall, out_reg2=0xFFFF8000.
- out_valid=1, out_ready=0 for 3 cycles -> all out_* stable, in_ready=0, stall_cnt unchanged; out_ready=1 -> next instruction loads.
- flush asserted during a load-use stall -> in_ready=0, out_valid=0 next cycle, stall_cnt not incremented that cycle; rst mid-stream -> all outputs 0 next cycle.
